wb_skid_stage: RTL and testbench

Parametrised memory-to-writeback pipeline stage with a valid/ready handshake, a two-entry skid buffer, and synchronous flush. It sits between the data-memory stage and the register-file writeback port. It replaces a plain always-load register: the writeback side can now stall without losing a beat, and the hazard unit can squash in-flight results.

---
 rtl/wb_skid_pkg.sv | 32 +++
 rtl/wb_skid_ctrl.sv | 82 ++++++++
 rtl/wb_skid_stage.sv | 79 +++++++
 tb/tb_wb_skid_stage.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/wb_skid_pkg.sv
// Shared types for the memory-to-writeback skid stage: entry payload, state encoding, occupancy width.
package wb_skid_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 4;
  localparam int FLAG_W = 4;
  localparam int OCC_W  = 2;

  typedef struct packed {
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] wr_data;
    logic [REG_W-1:0]  rd;
    logic              link;
    logic              wb_en;
    logic [FLAG_W-1:0] flags;
  } wb_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } wb_state_e;

  function automatic logic [OCC_W-1:0] occ_of(input wb_state_e st);
    unique case (st)
      ONE:     return OCC_W'(1);
      FULL:    return OCC_W'(2);
      default: return OCC_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/wb_skid_ctrl.sv
// Handshake state machine for the writeback skid stage; produces entry-register load strobes.
//   state | meaning
//   EMPTY | no entry held
//   ONE   | main entry valid, skid free
//   FULL  | main and skid both valid, upstream stalled
module wb_skid_ctrl
  import wb_skid_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OCC_W-1:0] occupancy,
  output logic             load_main,
  output logic             load_skid,
  output logic             main_from_skid
);

  wb_state_e state, state_nxt;
  logic      in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          load_main = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_from_skid = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Squashed cycles leave payload untouched; only the valids are dropped.
    if (flush) begin
      state_nxt      = EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  // Status outputs are registered from the next state so in_ready never sees out_ready combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      occupancy <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != EMPTY);
      in_ready  <= (state_nxt != FULL);
      occupancy <= occ_of(state_nxt);
    end
  end

endmodule

// File: rtl/wb_skid_stage.sv
// Memory-to-writeback pipeline stage with two-entry skid buffer and synchronous flush.
// Optional forwarding taps are enabled with `define WB_SKID_FORWARD_EN.
module wb_skid_stage
  import wb_skid_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_wr_data,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_link,
  input  logic              in_wb_en,
  input  logic [FLAG_W-1:0] in_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [DATA_W-1:0] out_wr_data,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_link,
  output logic              out_wb_en,
  output logic [FLAG_W-1:0] out_flags,
  output logic [OCC_W-1:0]  occupancy
`ifdef WB_SKID_FORWARD_EN
  ,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  wb_entry_t in_entry, main_q, skid_q;
  logic      load_main, load_skid, main_from_skid;

  assign in_entry = '{mem_data: in_mem_data, wr_data: in_wr_data, rd: in_rd,
                      link: in_link, wb_en: in_wb_en, flags: in_flags};

  wb_skid_ctrl u_ctrl (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .out_ready      (out_ready),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .occupancy      (occupancy),
    .load_main      (load_main),
    .load_skid      (load_skid),
    .main_from_skid (main_from_skid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)           main_q <= in_entry;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_entry;
    end
  end

  assign out_mem_data = main_q.mem_data;
  assign out_wr_data  = main_q.wr_data;
  assign out_rd       = main_q.rd;
  assign out_link     = main_q.link;
  assign out_flags    = main_q.flags;
  // Stale payload survives EMPTY/flush, so the write enable must be qualified.
  assign out_wb_en    = main_q.wb_en & out_valid;

`ifdef WB_SKID_FORWARD_EN
  assign fwd_valid = out_valid & main_q.wb_en;
  assign fwd_rd    = main_q.rd;
  assign fwd_data  = main_q.link ? main_q.wr_data : main_q.mem_data;
`endif

endmodule

// File: tb/tb_wb_skid_stage.sv
// Self-checking bench for wb_skid_stage: directed scenarios then random traffic against a queue model.
module tb_wb_skid_stage;
  import wb_skid_pkg::*;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, out_ready;
  logic              in_ready, out_valid, out_link, out_wb_en, in_link, in_wb_en;
  logic [DATA_W-1:0] in_mem_data, in_wr_data, out_mem_data, out_wr_data;
  logic [REG_W-1:0]  in_rd, out_rd;
  logic [FLAG_W-1:0] in_flags, out_flags;
  logic [OCC_W-1:0]  occupancy;
`ifdef WB_SKID_FORWARD_EN
  logic              fwd_valid;
  logic [REG_W-1:0]  fwd_rd;
  logic [DATA_W-1:0] fwd_data;
`endif

  always #5 clk = ~clk;

  wb_skid_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_data(in_mem_data), .in_wr_data(in_wr_data), .in_rd(in_rd),
    .in_link(in_link), .in_wb_en(in_wb_en), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mem_data(out_mem_data), .out_wr_data(out_wr_data), .out_rd(out_rd),
    .out_link(out_link), .out_wb_en(out_wb_en), .out_flags(out_flags),
    .occupancy(occupancy)
`ifdef WB_SKID_FORWARD_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  wb_entry_t q[$];
  bit        fields_zero;
  int        n_cmp = 0;
  int        n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic wb_entry_t mk(input logic [31:0] mem, input logic [31:0] wr,
                                   input logic [3:0] rd, input logic link, input logic wb);
    wb_entry_t e;
    e.mem_data = mem; e.wr_data = wr; e.rd = rd; e.link = link; e.wb_en = wb;
    e.flags = 4'($urandom);
    return e;
  endfunction

  function automatic wb_entry_t rnd();
    return mk($urandom, $urandom, 4'($urandom), 1'($urandom), 1'($urandom));
  endfunction

  task automatic check_outputs();
    wb_entry_t h;
    check("occupancy", 64'(occupancy), 64'(q.size()));
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() != 0) begin
      h = q[0];
      check("out_mem_data", 64'(out_mem_data), 64'(h.mem_data));
      check("out_wr_data", 64'(out_wr_data), 64'(h.wr_data));
      check("out_rd", 64'(out_rd), 64'(h.rd));
      check("out_link", 64'(out_link), 64'(h.link));
      check("out_flags", 64'(out_flags), 64'(h.flags));
      check("out_wb_en", 64'(out_wb_en), 64'(h.wb_en));
`ifdef WB_SKID_FORWARD_EN
      check("fwd_valid", 64'(fwd_valid), 64'(h.wb_en));
      check("fwd_rd", 64'(fwd_rd), 64'(h.rd));
      check("fwd_data", 64'(fwd_data), 64'(h.link ? h.wr_data : h.mem_data));
`endif
    end else begin
      check("out_wb_en_idle", 64'(out_wb_en), 64'd0);
`ifdef WB_SKID_FORWARD_EN
      check("fwd_valid_idle", 64'(fwd_valid), 64'd0);
`endif
      if (fields_zero) begin
        check("rst_mem_data", 64'(out_mem_data), 64'd0);
        check("rst_wr_data", 64'(out_wr_data), 64'd0);
        check("rst_rd", 64'(out_rd), 64'd0);
        check("rst_link", 64'(out_link), 64'd0);
        check("rst_flags", 64'(out_flags), 64'd0);
      end
    end
  endtask

  // One clock: drive inputs, advance the queue model across the edge, then compare.
  task automatic step(input logic rst, input logic fl, input logic iv,
                      input logic ordy, input wb_entry_t e);
    bit acc, rel;
    reset = rst; flush = fl; in_valid = iv; out_ready = ordy;
    in_mem_data = e.mem_data; in_wr_data = e.wr_data; in_rd = e.rd;
    in_link = e.link; in_wb_en = e.wb_en; in_flags = e.flags;
    acc = iv && (q.size() < 2);
    rel = ordy && (q.size() != 0);
    @(posedge clk);
    if (rst) begin
      q.delete();
      fields_zero = 1'b1;
    end else if (fl) begin
      q.delete();
    end else begin
      if (rel) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        fields_zero = 1'b0;
      end
      if (rel) fields_zero = 1'b0;
    end
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  initial begin
    wb_entry_t e, a, b, c, d;
    @(negedge clk);
    e = '0;
    step(1, 0, 0, 0, e);
    step(1, 0, 0, 0, e);

    // Single entry latency
    e = mk(32'hDEADBEEF, 32'h0, 4'h3, 1'b0, 1'b1);
    step(0, 0, 1, 1, e);
    check("t1_rd", 64'(out_rd), 64'h3);
    check("t1_mem", 64'(out_mem_data), 64'hDEADBEEF);
    step(0, 0, 0, 1, e);

    // Streaming wr_data 0..7
    for (int i = 0; i < 8; i++) begin
      e = mk($urandom, 32'(i), 4'($urandom), 1'b0, 1'b1);
      step(0, 0, 1, 1, e);
      check("stream_wr", 64'(out_wr_data), 64'(i));
      check("stream_rdy", 64'(in_ready), 64'd1);
    end
    step(0, 0, 0, 1, e);

    // Stall with A,B then C held upstream
    a = rnd(); b = rnd(); c = rnd();
    step(0, 0, 1, 0, a);
    step(0, 0, 1, 0, b);
    check("stall_occ", 64'(occupancy), 64'd2);
    step(0, 0, 1, 0, c);
    step(0, 0, 1, 1, c);
    check("drain_b", 64'(out_wr_data), 64'(b.wr_data));
    step(0, 0, 1, 1, c);
    check("drain_c", 64'(out_wr_data), 64'(c.wr_data));
    step(0, 0, 0, 1, c);

    // Flush while FULL with D offered
    a = rnd(); b = rnd(); d = rnd(); d.wb_en = 1'b1;
    step(0, 0, 1, 0, a);
    step(0, 0, 1, 0, b);
    step(0, 1, 1, 0, d);
    check("flush_occ", 64'(occupancy), 64'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, d);

    // Reset while FULL with flush
    a = rnd(); b = rnd();
    step(0, 0, 1, 0, a);
    step(0, 0, 1, 0, b);
    step(1, 1, 1, 1, rnd());
    check("rst_rdy", 64'(in_ready), 64'd1);
    e = rnd();
    step(0, 0, 1, 1, e);
    step(0, 0, 0, 1, e);

    // Forwarding entry with link, then same entry without writeback
    e = mk(32'h55, 32'h100, 4'hE, 1'b1, 1'b1);
    step(0, 0, 1, 1, e);
    e.wb_en = 1'b0;
    step(0, 0, 1, 1, e);
    step(0, 0, 0, 1, e);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) == 0), ($urandom_range(24) == 0),
           ($urandom_range(9) < 7), ($urandom_range(9) < 6), rnd());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
